btb_2way: RTL

Two-way set-associative branch target buffer with per-entry 2-bit direction counters and per-set LRU replacement. It sits in the fetch stage and predicts using the fetch PC. It is trained from the execute stage through a separate update port. The lookup path is registered, giving one cycle of latency. Set count and address width are parameters.

---
 rtl/btb_2way.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/btb_2way.sv
// rtl/btb_2way.sv - two-way set-associative branch target buffer with LRU and optional direction counters (BTB_DIR_COUNTER_EN)
module btb_2way #(
   parameter int ADDR_W   = 32,
   parameter int SET_BITS = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lookup_en,
   input  logic [ADDR_W-1:0] pc,
   input  logic              update,
   input  logic [ADDR_W-1:0] update_pc,
   input  logic              update_taken,
   input  logic [ADDR_W-1:0] update_target,
   input  logic              flush,
   output logic              hit,
   output logic              miss,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] btb_target
);

   localparam int TAG_W = ADDR_W - SET_BITS - 2;
   localparam int SETS  = 1 << SET_BITS;

   // Per-entry and per-set state; lru names the way to victimise next
   logic              valid_q [2][SETS];
   logic              lru_q   [SETS];
   logic [TAG_W-1:0]  tag_q   [2][SETS];
   logic [ADDR_W-1:0] tgt_q   [2][SETS];
`ifdef BTB_DIR_COUNTER_EN
   logic [1:0]        ctr_q   [2][SETS];
   logic [1:0]        ctr_cur;
   logic [1:0]        ctr_nxt;
`endif

   // Lookup side
   logic [SET_BITS-1:0] l_idx;
   logic [TAG_W-1:0]    l_tag;
   logic                l_hit0;
   logic                l_hit1;
   logic                l_pred0;
   logic                l_pred1;

   // Update side
   logic [SET_BITS-1:0] u_idx;
   logic [TAG_W-1:0]    u_tag;
   logic                u_hit0;
   logic                u_hit1;
   logic                u_hit;
   logic                victim;
   logic                do_upd;
   logic                wr_tgt;
   logic                wr_alloc;
   logic                wr_way;
   logic                nt_hit;

   // Byte-offset bits of the PCs carry no information for the BTB
   logic unused_bits;
   assign unused_bits = ^{pc[1:0], update_pc[1:0]};

   // Tag compare against both ways of the fetch set; way 0 wins a double match
   always_comb begin
      l_idx   = pc[SET_BITS+1:2];
      l_tag   = pc[ADDR_W-1:SET_BITS+2];
      l_hit0  = valid_q[0][l_idx] && (tag_q[0][l_idx] == l_tag);
      l_hit1  = valid_q[1][l_idx] && (tag_q[1][l_idx] == l_tag);
`ifdef BTB_DIR_COUNTER_EN
      l_pred0 = ctr_q[0][l_idx][1];
      l_pred1 = ctr_q[1][l_idx][1];
`else
      l_pred0 = 1'b1;
      l_pred1 = 1'b1;
`endif
   end

   // Registered lookup result; reads pre-update, pre-flush state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit        <= 1'b0;
         miss       <= 1'b0;
         pred_taken <= 1'b0;
         btb_target <= '0;
      end else if (!lookup_en) begin
         hit        <= 1'b0;
         miss       <= 1'b0;
         pred_taken <= 1'b0;
         btb_target <= '0;
      end else if (l_hit0) begin
         hit        <= 1'b1;
         miss       <= 1'b0;
         pred_taken <= l_pred0;
         btb_target <= tgt_q[0][l_idx];
      end else if (l_hit1) begin
         hit        <= 1'b1;
         miss       <= 1'b0;
         pred_taken <= l_pred1;
         btb_target <= tgt_q[1][l_idx];
      end else begin
         hit        <= 1'b0;
         miss       <= 1'b1;
         pred_taken <= 1'b0;
         btb_target <= '0;
      end
   end

   // Decode the training request: hit way, victim choice and write strobes
   always_comb begin
      u_idx    = update_pc[SET_BITS+1:2];
      u_tag    = update_pc[ADDR_W-1:SET_BITS+2];
      u_hit0   = valid_q[0][u_idx] && (tag_q[0][u_idx] == u_tag);
      u_hit1   = valid_q[1][u_idx] && (tag_q[1][u_idx] == u_tag);
      u_hit    = u_hit0 || u_hit1;
      if (!valid_q[0][u_idx])
         victim = 1'b0;
      else if (!valid_q[1][u_idx])
         victim = 1'b1;
      else
         victim = lru_q[u_idx];
      // Flush drops a same-cycle update entirely
      do_upd   = update && !flush;
      wr_way   = u_hit ? !u_hit0 : victim;
      wr_tgt   = do_upd && update_taken;
      wr_alloc = do_upd && update_taken && !u_hit;
      nt_hit   = do_upd && !update_taken && u_hit;
   end

   // Valid and LRU state; flush clears both in one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[0][s] <= 1'b0;
            valid_q[1][s] <= 1'b0;
            lru_q[s]      <= 1'b0;
         end
      end else if (flush) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[0][s] <= 1'b0;
            valid_q[1][s] <= 1'b0;
            lru_q[s]      <= 1'b0;
         end
      end else begin
         if (wr_alloc)
            valid_q[wr_way][u_idx] <= 1'b1;
`ifndef BTB_DIR_COUNTER_EN
         // Without counters a not-taken hit simply drops the entry
         if (nt_hit)
            valid_q[wr_way][u_idx] <= 1'b0;
`endif
         if (wr_tgt)
            lru_q[u_idx] <= !wr_way;
      end
   end

   // Tag and target storage needs no reset; valid bits gate every use
   always_ff @(posedge clk) begin
      if (wr_tgt)
         tgt_q[wr_way][u_idx] <= update_target;
      if (wr_alloc)
         tag_q[wr_way][u_idx] <= u_tag;
   end

`ifdef BTB_DIR_COUNTER_EN
   // Saturating 2-bit counter step; a fresh allocation starts weakly taken
   always_comb begin
      ctr_cur = ctr_q[wr_way][u_idx];
      if (wr_alloc)
         ctr_nxt = 2'b10;
      else if (update_taken)
         ctr_nxt = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'b01;
      else
         ctr_nxt = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'b01;
   end

   // Counter storage; untouched by flush
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            ctr_q[0][s] <= 2'b00;
            ctr_q[1][s] <= 2'b00;
         end
      end else if (wr_tgt || nt_hit) begin
         ctr_q[wr_way][u_idx] <= ctr_nxt;
      end
   end
`endif

endmodule
